// File: rtl/ras_spec_ctrl_pkg.sv
// Shared encodings for the RAS speculation controller and its journal.
package ras_spec_ctrl_pkg;

    // Journal entry type. Bit 0 records a call and bit 1 records a return.
    typedef enum logic [1:0] {
        JT_NONE    = 2'b00,
        JT_CALL    = 2'b01,
        JT_RET     = 2'b10,
        JT_CALLRET = 2'b11
    } jtype_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_ROLLBACK = 1'b1
    } state_e;

endpackage

// File: rtl/ras_spec_ctrl_if.sv
// Fetch, commit/flush and RAS-side signals of the speculation controller.
interface ras_spec_ctrl_if #(
    parameter int JDEPTH_W = 3
);
    logic                fe_valid;
    logic                fe_is_call;
    logic                fe_is_ret;
    logic                fe_ready;
    logic                retire_valid;
    logic                flush;
    logic                ras_push;
    logic                ras_pop;
    logic                ras_rollback_push;
    logic                ras_rollback_pop;
    logic                busy;
    logic [JDEPTH_W:0]   jcount;

    modport master (
        output fe_valid, fe_is_call, fe_is_ret, retire_valid, flush,
        input  fe_ready, ras_push, ras_pop, ras_rollback_push,
               ras_rollback_pop, busy, jcount
    );

    modport slave (
        input  fe_valid, fe_is_call, fe_is_ret, retire_valid, flush,
        output fe_ready, ras_push, ras_pop, ras_rollback_push,
               ras_rollback_pop, busy, jcount
    );
endinterface

// File: rtl/ras_journal_fifo.sv
// Circular journal: push at tail, pop at head, retract the youngest entry at tail-1.
module ras_journal_fifo #(
    parameter int DEPTH_W = 3,
    parameter int WIDTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic               pop_i,
    input  logic               retract_i,
    output logic [WIDTH-1:0]   top_o,
    output logic [DEPTH_W:0]   count_o
);
    localparam int                 DEPTH   = 1 << DEPTH_W;
    localparam logic [DEPTH_W-1:0] PTR_ONE = (DEPTH_W)'(1);
    localparam logic [DEPTH_W:0]   CNT_ONE = (DEPTH_W+1)'(1);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [DEPTH_W-1:0] head_q;
    logic [DEPTH_W-1:0] tail_q;
    logic [DEPTH_W-1:0] top_idx;
    logic [DEPTH_W:0]   count_q;
    logic [DEPTH_W:0]   count_d;

    // Pop and retract never coincide: retract only happens during rollback.
    always_comb begin
        count_d = count_q;
        if (push_i)
            count_d = count_d + CNT_ONE;
        if (pop_i || retract_i)
            count_d = count_d - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i)
                tail_q <= tail_q + PTR_ONE;
            else if (retract_i)
                tail_q <= tail_q - PTR_ONE;
            if (pop_i)
                head_q <= head_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i)
            mem_q[tail_q] <= data_i;
    end

    assign top_idx = tail_q - PTR_ONE;
    assign top_o   = mem_q[top_idx];
    assign count_o = count_q;

endmodule

// File: rtl/ras_spec_ctrl.sv
// RAS speculation controller: forward push/pop strobes, journal, youngest-first rollback on flush.
// Optional statistics counters when RAS_SPEC_CTRL_STATS_EN is defined.
module ras_spec_ctrl
    import ras_spec_ctrl_pkg::*;
#(
    parameter int JDEPTH_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    ras_spec_ctrl_if.slave     bus
`ifdef RAS_SPEC_CTRL_STATS_EN
    ,
    output logic [31:0]        stat_flushes,
    output logic [31:0]        stat_rb_cycles,
    output logic [31:0]        stat_lost
`endif
);
    localparam int               JDEPTH   = 1 << JDEPTH_W;
    localparam logic [JDEPTH_W:0] CNT_FULL = (JDEPTH_W+1)'(JDEPTH);
    localparam logic [JDEPTH_W:0] CNT_ONE  = (JDEPTH_W+1)'(1);

    state_e              state_q;
    logic [JDEPTH_W:0]   jcount;
    logic [1:0]          top_type;
    logic                rb_active;
    logic                fe_ready;
    logic                fire;
    logic                retire_ok;
    logic                go_rb;

    assign rb_active = (state_q == ST_ROLLBACK);
    assign fe_ready  = !rb_active && !bus.flush && (jcount < CNT_FULL);
    assign fire      = bus.fe_valid && fe_ready && (bus.fe_is_call || bus.fe_is_ret);
    assign retire_ok = !rb_active && bus.retire_valid && (jcount != '0);
    // The mispredicting instruction commits with the flush, so its retire is counted first.
    assign go_rb     = !rb_active && bus.flush &&
                       (retire_ok ? (jcount > CNT_ONE) : (jcount != '0));

    ras_journal_fifo #(
        .DEPTH_W (JDEPTH_W),
        .WIDTH   (2)
    ) u_journal (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (fire),
        .data_i    ({bus.fe_is_ret, bus.fe_is_call}),
        .pop_i     (retire_ok),
        .retract_i (rb_active),
        .top_o     (top_type),
        .count_o   (jcount)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:     if (go_rb) state_q <= ST_ROLLBACK;
                ST_ROLLBACK: if (jcount == CNT_ONE) state_q <= ST_IDLE;
                default:     state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.fe_ready          = fe_ready;
    assign bus.ras_push          = fire && bus.fe_is_call;
    assign bus.ras_pop           = fire && bus.fe_is_ret;
    // A CALLRET entry has overwritten its slot, so it is retracted with no strobe.
    assign bus.ras_rollback_push = rb_active && (top_type == JT_RET);
    assign bus.ras_rollback_pop  = rb_active && (top_type == JT_CALL);
    assign bus.busy              = rb_active;
    assign bus.jcount            = jcount;

    assert property (@(posedge clk) disable iff (!rst_n)
        !(!rb_active && bus.retire_valid && (jcount == '0)));

`ifdef RAS_SPEC_CTRL_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_flushes   <= '0;
            stat_rb_cycles <= '0;
            stat_lost      <= '0;
        end else begin
            if (go_rb)
                stat_flushes <= sat_inc(stat_flushes);
            if (rb_active)
                stat_rb_cycles <= sat_inc(stat_rb_cycles);
            if (rb_active && (top_type == JT_CALLRET))
                stat_lost <= sat_inc(stat_lost);
        end
    end
`endif

endmodule

// File: tb/tb_ras_spec_ctrl.sv
// Scoreboard bench for ras_spec_ctrl: directed cycle vectors, monitor compares at negedge.
module tb_ras_spec_ctrl;
    localparam int JW = 3;

    // Flag vector order: {fe_ready, ras_push, ras_pop, rollback_push, rollback_pop, busy}
    localparam logic [5:0] IDL = 6'b100000;
    localparam logic [5:0] PSH = 6'b110000;
    localparam logic [5:0] POP = 6'b101000;
    localparam logic [5:0] PP  = 6'b111000;
    localparam logic [5:0] STL = 6'b000000;
    localparam logic [5:0] RBU = 6'b000101;
    localparam logic [5:0] RBO = 6'b000011;
    localparam logic [5:0] RBN = 6'b000001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ras_spec_ctrl_if #(.JDEPTH_W(JW)) bus ();

`ifdef RAS_SPEC_CTRL_STATS_EN
    logic [31:0] stat_flushes, stat_rb_cycles, stat_lost;
`endif

    ras_spec_ctrl #(.JDEPTH_W(JW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef RAS_SPEC_CTRL_STATS_EN
        ,
        .stat_flushes   (stat_flushes),
        .stat_rb_cycles (stat_rb_cycles),
        .stat_lost      (stat_lost)
`endif
    );

    typedef struct {
        string       nm;
        logic [5:0]  o;
        logic [JW:0] jc;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nmis = 0;

    always @(negedge clk) begin
        exp_t       e;
        logic [5:0] got;
        if (q.size() > 0) begin
            e   = q.pop_front();
            got = {bus.fe_ready, bus.ras_push, bus.ras_pop,
                   bus.ras_rollback_push, bus.ras_rollback_pop, bus.busy};
            nvec++;
            if (got !== e.o || bus.jcount !== e.jc) begin
                nmis++;
                $display("FAIL %s: got flags=%b jcount=%0d, want flags=%b jcount=%0d",
                         e.nm, got, bus.jcount, e.o, e.jc);
            end
        end
    end

    task automatic step(input string nm, input bit fv, input bit ca, input bit re,
                        input bit rv, input bit fl, input logic [5:0] eo,
                        input int ej, input bit rn = 1'b1);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n            = rn;
        bus.fe_valid     = fv;
        bus.fe_is_call   = ca;
        bus.fe_is_ret    = re;
        bus.retire_valid = rv;
        bus.flush        = fl;
        e.nm = nm;
        e.o  = eo;
        e.jc = (JW+1)'(ej);
        q.push_back(e);
    endtask

`ifdef RAS_SPEC_CTRL_STATS_EN
    task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nmis++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask
`endif

    initial begin
        bus.fe_valid     = 1'b0;
        bus.fe_is_call   = 1'b0;
        bus.fe_is_ret    = 1'b0;
        bus.retire_valid = 1'b0;
        bus.flush        = 1'b0;

        step("reset_state", 0, 0, 0, 0, 0, IDL, 0, 1'b0);
        step("idle_after_reset", 0, 0, 0, 0, 0, IDL, 0);

        // call, call, ret, flush, three-entry rollback
        step("t1_call0", 1, 1, 0, 0, 0, PSH, 0);
        step("t1_call1", 1, 1, 0, 0, 0, PSH, 1);
        step("t1_ret",   1, 0, 1, 0, 0, POP, 2);
        step("t1_flush", 0, 0, 0, 0, 1, STL, 3);
        step("t1_rb1",   0, 0, 0, 0, 0, RBU, 3);
        step("t1_rb2",   0, 0, 0, 0, 0, RBO, 2);
        step("t1_rb3",   0, 0, 0, 0, 0, RBO, 1);
        step("t1_idle",  0, 0, 0, 0, 0, IDL, 0);

        // fill to full, stall, retire, wrap the tail with a RET, then roll back all eight
        for (int i = 0; i < 8; i++)
            step($sformatf("t2_call%0d", i), 1, 1, 0, 0, 0, PSH, i);
        step("t2_full_call",   1, 1, 0, 0, 0, STL, 8);
        step("t2_full_plain",  1, 0, 0, 0, 0, STL, 8);
        step("t2_retire",      0, 0, 0, 1, 0, STL, 8);
        step("t2_wrap_ret",    1, 0, 1, 0, 0, POP, 7);
        step("t2_flush",       0, 0, 0, 0, 1, STL, 8);
        step("t2_rb_wrapslot", 0, 0, 0, 0, 0, RBU, 8);
        for (int i = 7; i >= 1; i--)
            step($sformatf("t2_rb_jc%0d", i), 0, 0, 0, 0, 0, RBO, i);
        step("t2_idle", 0, 0, 0, 0, 0, IDL, 0);

        // non-RAS fetch, fire with retire, flush with retire at jcount 1
        step("t3_plain",       1, 0, 0, 0, 0, IDL, 0);
        step("t3_call",        1, 1, 0, 0, 0, PSH, 0);
        step("t3_call_retire", 1, 1, 0, 1, 0, PSH, 1);
        step("t3_flush_retire", 0, 0, 0, 1, 1, STL, 1);
        step("t3_no_rb",       0, 0, 0, 0, 0, IDL, 0);
        step("t3_still_idle",  0, 0, 0, 0, 0, IDL, 0);

        // CALLRET entry: rollback cycle with no strobe
        step("t4_callret", 1, 1, 1, 0, 0, PP,  0);
        step("t4_flush",   0, 0, 0, 0, 1, STL, 1);
        step("t4_rb_lost", 0, 0, 0, 0, 0, RBN, 1);
        step("t4_idle",    0, 0, 0, 0, 0, IDL, 0);
`ifdef RAS_SPEC_CTRL_STATS_EN
        chk32("stat_flushes",   stat_flushes,   32'd3);
        chk32("stat_rb_cycles", stat_rb_cycles, 32'd12);
        chk32("stat_lost",      stat_lost,      32'd1);
`endif

        // flush blocks a simultaneous call
        step("t5_flush_call", 1, 1, 0, 0, 1, STL, 0);
        step("t5_not_logged", 0, 0, 0, 0, 0, IDL, 0);

        // reset during a four-entry rollback
        for (int i = 0; i < 4; i++)
            step($sformatf("t6_call%0d", i), 1, 1, 0, 0, 0, PSH, i);
        step("t6_flush",   0, 0, 0, 0, 1, STL, 4);
        step("t6_rb1",     0, 0, 0, 0, 0, RBO, 4);
        step("t6_rb2_rst", 0, 0, 0, 0, 0, RBO, 3, 1'b0);
        step("t6_aborted", 0, 0, 0, 0, 0, IDL, 0);
        step("t6_idle",    0, 0, 0, 0, 0, IDL, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge clk);
        @(posedge clk);
        if (q.size() > 0) begin
            nvec++;
            nmis++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
